present_engine: RTL

- Parametrised PRESENT block-cipher engine, one round per cycle; successor to the fixed 128-bit-key, encrypt-only core.
- Adds selectable key size (80/128), run-time encrypt/decrypt mode, valid/ready handshakes on both sides, and a cached decryption-key expansion.
- Sits behind the Avalon accelerator register interface.

---
 rtl/present_engine.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/present_engine.sv
// PRESENT block cipher, one round per cycle, 80/128-bit key.
// Encrypt/decrypt with a cached final round key for decryption.
module present_engine #(
  parameter int KEY_WIDTH = 128,
  parameter int NB_ROUNDS = 31
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 decrypt,
  input  logic [63:0]          data_in,
  input  logic [KEY_WIDTH-1:0] key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          data_out,
  output logic                 busy
);

  localparam int KW = KEY_WIDTH;
  localparam int CLO = (KW == 80) ? 15 : 62;
  localparam logic [4:0] NR = 5'(NB_ROUNDS);

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };
  localparam logic [3:0] SINV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [1:0] {
    IDLE, KEYEXP, ROUND, DONE
  } state_e;

  function automatic logic [63:0] s_layer(
    input logic [63:0] x
  );
    logic [63:0] o;
    for (int n = 0; n < 16; n++)
      o[4*n +: 4] = SBOX[x[4*n +: 4]];
    return o;
  endfunction

  function automatic logic [63:0] si_layer(
    input logic [63:0] x
  );
    logic [63:0] o;
    for (int n = 0; n < 16; n++)
      o[4*n +: 4] = SINV[x[4*n +: 4]];
    return o;
  endfunction

  // bit j moves to 16*j mod 63; bit 63 stays
  function automatic logic [63:0] p_layer(
    input logic [63:0] x
  );
    logic [63:0] o;
    o[63] = x[63];
    for (int j = 0; j < 63; j++)
      o[(16*j) % 63] = x[j];
    return o;
  endfunction

  function automatic logic [63:0] pi_layer(
    input logic [63:0] x
  );
    logic [63:0] o;
    o[63] = x[63];
    for (int j = 0; j < 63; j++)
      o[j] = x[(16*j) % 63];
    return o;
  endfunction

  function automatic logic [KW-1:0] ks_fwd(
    input logic [KW-1:0] k,
    input logic [4:0]    i
  );
    logic [KW-1:0] r;
    r = {k[KW-62:0], k[KW-1:KW-61]};
    r[KW-1:KW-4] = SBOX[r[KW-1:KW-4]];
    if (KW == 128)
      r[KW-5:KW-8] = SBOX[r[KW-5:KW-8]];
    r[CLO +: 5] = r[CLO +: 5] ^ i;
    return r;
  endfunction

  function automatic logic [KW-1:0] ks_inv(
    input logic [KW-1:0] k,
    input logic [4:0]    i
  );
    logic [KW-1:0] r;
    r = k;
    r[CLO +: 5] = r[CLO +: 5] ^ i;
    if (KW == 128)
      r[KW-5:KW-8] = SINV[r[KW-5:KW-8]];
    r[KW-1:KW-4] = SINV[r[KW-1:KW-4]];
    return {r[60:0], r[KW-1:61]};
  endfunction

  state_e        st_q, st_d;
  logic [63:0]   blk_q, blk_d;
  logic [KW-1:0] rk_q, rk_d;
  logic [4:0]    i_q, i_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          dec_q, dec_d;
  logic [63:0]   dout_q, dout_d;
  logic          ov_q, ov_d;
  logic          cv_q, cv_d;
  logic [KW-1:0] ck_q, ck_d;
  logic [KW-1:0] dk_q, dk_d;

  logic [63:0]   mix;
  logic [KW-1:0] rk_fwd;
  logic [KW-1:0] rk_inv;
  logic          hit;

  assign mix    = blk_q ^ rk_q[KW-1:KW-64];
  assign rk_fwd = ks_fwd(rk_q, i_q);
  assign rk_inv = ks_inv(rk_q, i_q);
  assign hit    = cv_q && (key == ck_q);

  assign in_ready  = (st_q == IDLE);
  assign busy      = (st_q == KEYEXP) || (st_q == ROUND);
  assign out_valid = ov_q;
  assign data_out  = dout_q;

  always_comb begin
    st_d   = st_q;
    blk_d  = blk_q;
    rk_d   = rk_q;
    i_d    = i_q;
    cnt_d  = cnt_q;
    dec_d  = dec_q;
    dout_d = dout_q;
    ov_d   = ov_q;
    cv_d   = cv_q;
    ck_d   = ck_q;
    dk_d   = dk_q;
    unique case (st_q)
      IDLE: begin
        if (in_valid) begin
          blk_d = data_in;
          dec_d = decrypt;
          cnt_d = 5'd0;
          if (!decrypt) begin
            rk_d = key;
            i_d  = 5'd1;
            st_d = ROUND;
          end else if (hit) begin
            rk_d = dk_q;
            i_d  = NR;
            st_d = ROUND;
          end else begin
            // cache invalid until this expansion completes
            rk_d = key;
            i_d  = 5'd1;
            ck_d = key;
            cv_d = 1'b0;
            st_d = KEYEXP;
          end
        end
      end
      KEYEXP: begin
        rk_d  = rk_fwd;
        cnt_d = cnt_q + 5'd1;
        i_d   = i_q + 5'd1;
        if (cnt_q == NR - 5'd1) begin
          dk_d  = rk_fwd;
          cv_d  = 1'b1;
          cnt_d = 5'd0;
          i_d   = NR;
          st_d  = ROUND;
        end
      end
      ROUND: begin
        if (cnt_q == NR) begin
          dout_d = mix;
          ov_d   = 1'b1;
          st_d   = DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (dec_q) begin
            blk_d = si_layer(pi_layer(mix));
            rk_d  = rk_inv;
            if (cnt_q != NR - 5'd1)
              i_d = i_q - 5'd1;
          end else begin
            blk_d = p_layer(s_layer(mix));
            rk_d  = rk_fwd;
            if (cnt_q != NR - 5'd1)
              i_d = i_q + 5'd1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d = 1'b0;
          st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st_q   <= IDLE;
      blk_q  <= '0;
      rk_q   <= '0;
      i_q    <= '0;
      cnt_q  <= '0;
      dec_q  <= 1'b0;
      dout_q <= '0;
      ov_q   <= 1'b0;
      cv_q   <= 1'b0;
      ck_q   <= '0;
      dk_q   <= '0;
    end else begin
      st_q   <= st_d;
      blk_q  <= blk_d;
      rk_q   <= rk_d;
      i_q    <= i_d;
      cnt_q  <= cnt_d;
      dec_q  <= dec_d;
      dout_q <= dout_d;
      ov_q   <= ov_d;
      cv_q   <= cv_d;
      ck_q   <= ck_d;
      dk_q   <= dk_d;
    end
  end

endmodule
